// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of the step counter for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division step: shift in a dividend bit, conditionally subtract.
module divider_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] dvs_ext;

  // Compare the shifted partial remainder against the divisor and restore on miss.
  always_comb begin
    rem_sh   = {rem, din};
    dvs_ext  = {2'b00, divisor};
    qbit     = (rem_sh >= dvs_ext);
    rem_next = qbit ? (WIDTH+1)'(rem_sh - dvs_ext) : rem_sh[WIDTH:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative restoring integer divider, one quotient bit per cycle.
// Build option: define DIVIDER_SIGNED_EN for two's complement operands/results.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] dvd, dvd_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic [WIDTH:0]   rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] a_hold, a_hold_d;
  logic [WIDTH-1:0] q_d, r_d;
  logic             dbz_d;
  logic             out_valid_d, in_ready_d;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
`ifdef DIVIDER_SIGNED_EN
  logic             q_neg, q_neg_d;
  logic             r_neg, r_neg_d;
`endif

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  // Next-state, datapath and output logic.
  always_comb begin
    state_d  = state;
    dvd_d    = dvd;
    dvs_d    = dvs;
    rem_d    = rem;
    quo_d    = quo;
    cnt_d    = cnt;
    a_hold_d = a_hold;
    q_d      = q;
    r_d      = r;
    dbz_d    = div_by_zero;
`ifdef DIVIDER_SIGNED_EN
    q_neg_d  = q_neg;
    r_neg_d  = r_neg;
`endif

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_hold_d = a;
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = CNT_LAST;
`ifdef DIVIDER_SIGNED_EN
          dvd_d    = a[WIDTH-1] ? WIDTH'(-a) : a;
          dvs_d    = b[WIDTH-1] ? WIDTH'(-b) : b;
          q_neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_d  = a[WIDTH-1];
`else
          dvd_d    = a;
          dvs_d    = b;
`endif
          state_d  = BUSY;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        dvd_d = {dvd[WIDTH-2:0], 1'b0};
        quo_d = {quo[WIDTH-2:0], step_q};
        cnt_d = cnt - CW'(1);
        if (cnt == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dvs == '0) begin
          q_d   = '1;
          r_d   = a_hold;
          dbz_d = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
          q_d   = q_neg ? WIDTH'(-quo) : quo;
          r_d   = r_neg ? WIDTH'(-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
`else
          q_d   = quo;
          r_d   = rem[WIDTH-1:0];
`endif
          dbz_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      a_hold      <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      dvd         <= dvd_d;
      dvs         <= dvs_d;
      rem         <= rem_d;
      quo         <= quo_d;
      cnt         <= cnt_d;
      a_hold      <= a_hold_d;
      q           <= q_d;
      r           <= r_d;
      div_by_zero <= dbz_d;
      out_valid   <= out_valid_d;
      in_ready    <= in_ready_d;
`ifdef DIVIDER_SIGNED_EN
      q_neg       <= q_neg_d;
      r_neg       <= r_neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider; honours DIVIDER_SIGNED_EN like the RTL.
module tb_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic division with the documented zero-divisor result.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] eq, output logic [W-1:0] er,
                       output logic edbz);
`ifdef DIVIDER_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(ma);
    sb = $signed(mb);
`endif
    if (mb == 0) begin
      eq   = '1;
      er   = ma;
      edbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      eq = W'(sa / sb);
      er = W'(sa % sb);
`else
      eq = ma / mb;
      er = ma % mb;
`endif
      edbz = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: issue, wait for result, hold under backpressure, consume.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold,
                       input bit junk);
    logic [W-1:0] eq, er;
    logic         edbz;
    int           lat;
    model(ta, tb_, eq, er, edbz);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < int'(W) + 10) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      if (junk) begin
        in_valid = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(W + 1));
    check("q", 32'(q), 32'(eq));
    check("r", 32'(r), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edbz));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_q", 32'(q), 32'(eq));
      check("hold_r", 32'(r), 32'(er));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    if (junk) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("consumed_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases.
    do_op(8'd100, 8'd7, 0, 1'b0);
    check("q_100_7", 32'(q), 32'd14);
    do_op(8'd255, 8'd1, 0, 1'b0);
    do_op(8'd5,   8'd9, 0, 1'b0);
    do_op(8'd200, 8'd0, 20, 1'b0);
    do_op(8'd37,  8'd6, 0, 1'b0);
`ifdef DIVIDER_SIGNED_EN
    do_op(8'hF9, 8'h02, 0, 1'b0);
    check("q_m7_2", 32'(q), 32'hFD);
    do_op(8'h07, 8'hFE, 0, 1'b0);
    do_op(8'h80, 8'hFF, 0, 1'b0);
    check("q_min_m1", 32'(q), 32'h80);
    do_op(8'hF7, 8'h00, 3, 1'b0);
`endif

    // Reset in the middle of a division.
    in_valid = 1'b1;
    a        = 8'd100;
    b        = 8'd0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_q", 32'(q), 32'd0);
    check("midrst_r", 32'(r), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    do_op(8'd50, 8'd5, 0, 1'b0);
    check("q_50_5", 32'(q), 32'd10);

    // Random operands with random gaps and backpressure.
    for (int n = 0; n < 2000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = 8'd1;
        2: begin ra = 8'h80; rb = 8'hFF; end
        3: rb = W'($urandom_range(1, 15));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) tick();
      do_op(ra, rb, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
